opm_write_queue: RTL

// Host-bus write front end for one or more jt51 cores. Synchronises asynchronous
// 6800/8080-style writes into clk, queues them in a shared FIFO, and paces delivery
// to each core. Address writes and data writes get separate minimum gaps.

---
 rtl/opm_write_queue_if.sv | 32 +++
 rtl/opm_write_queue.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/opm_write_queue_if.sv
// Host-side write strobes and core-side dispatch signals of the jt51 write queue.
// The slave modport is the queue itself; the master modport is the host/core side.
interface opm_write_queue_if #(
  parameter int NCHIP = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [NCHIP-1:0] cs_n;
  logic             wr_n;
  logic             a0;
  logic [DW-1:0]    din;
  logic             cen;
  logic [NCHIP-1:0] core_busy;
  logic             clr_ovf;
  logic [NCHIP-1:0] core_wr;
  logic             core_a0;
  logic [DW-1:0]    core_din;
  logic [NCHIP-1:0] busy;
  logic [LW-1:0]    level;
  logic             ovf;

  modport slave (
    input  cs_n, wr_n, a0, din, cen, core_busy, clr_ovf,
    output core_wr, core_a0, core_din, busy, level, ovf
  );
  modport master (
    output cs_n, wr_n, a0, din, cen, core_busy, clr_ovf,
    input  core_wr, core_a0, core_din, busy, level, ovf
  );
endinterface

// File: rtl/opm_write_queue.sv
// Synchronises async host writes, queues them in a shared FIFO and paces
// delivery to each jt51 core with separate address/data gaps.
module opm_write_queue #(
  parameter int NCHIP       = 2,
  parameter int DW          = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_ADDR    = 2,
  parameter int GAP_DATA    = 68
) (
  input logic             clk,
  input logic             rst,
  opm_write_queue_if.slave bus
);
  localparam int CW   = (NCHIP > 1) ? $clog2(NCHIP) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int PW   = $clog2(DEPTH + 2);
  localparam int GMAX = (GAP_DATA > GAP_ADDR) ? GAP_DATA : GAP_ADDR;
  localparam int GW   = $clog2(GMAX + 1) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  typedef struct packed {
    logic [CW-1:0] chip;
    logic          a0;
    logic [DW-1:0] d;
  } entry_t;

  logic [NCHIP-1:0][SYNC_STAGES-1:0] sync;
  logic [NCHIP-1:0]                  last_q, rise, st0;
  logic [DW:0]                       hold;

  genvar c;
  generate
    for (c = 0; c < NCHIP; c++) begin : g_sync
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          sync[c]   <= '1;
          last_q[c] <= 1'b1;
        end else begin
          sync[c]   <= {sync[c][SYNC_STAGES-2:0], bus.wr_n | bus.cs_n[c]};
          last_q[c] <= sync[c][SYNC_STAGES-1];
        end
      assign st0[c]  = sync[c][0];
      assign rise[c] = sync[c][SYNC_STAGES-1] & ~last_q[c];
    end
  endgenerate

  // a0/din are only guaranteed while the strobe is low, so keep the last sample
  always_ff @(posedge clk or posedge rst)
    if (rst)        hold <= '0;
    else if (~&st0) hold <= {bus.a0, bus.din};

  logic [CW-1:0] push_c;
  logic          push_req, multi;
  always_comb begin
    push_c = '0;
    for (int i = NCHIP - 1; i >= 0; i--)
      if (rise[i]) push_c = CW'(i);
    push_req = |rise;
    multi    = (rise & (rise - NCHIP'(1))) != '0;
  end

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [LW-1:0] wp, rp, lvl;
  logic          empty, full, pop, push_ok;
  logic [1:0]    state;
  logic [CW-1:0] cur;
  logic [GW-1:0] gcnt;
  logic          done;

  assign lvl     = wp - rp;
  assign empty   = (wp == rp);
  assign full    = (lvl == LW'(DEPTH));
  assign head    = mem[rp[AW-1:0]];
  assign pop     = (state == IDLE) && !empty && !bus.core_busy[head.chip];
  assign push_ok = push_req && (!full || pop);
  assign done    = (state == GAP) && (gcnt == '0);
  assign bus.level = lvl;

  always_ff @(posedge clk)
    if (push_ok) mem[wp[AW-1:0]] <= '{chip: push_c, a0: hold[DW], d: hold[DW-1:0]};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      bus.ovf <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + LW'(1);
      if (pop)     rp <= rp + LW'(1);
      // a same-cycle drop wins over the clear
      if (push_req && (multi || (full && !pop))) bus.ovf <= 1'b1;
      else if (bus.clr_ovf)                      bus.ovf <= 1'b0;
    end

  logic [NCHIP-1:0][PW-1:0] pend;
  generate
    for (c = 0; c < NCHIP; c++) begin : g_pend
      logic inc, dec;
      assign inc = push_ok && (push_c == CW'(c));
      assign dec = done && (cur == CW'(c));
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          pend[c]     <= '0;
          bus.busy[c] <= 1'b0;
        end else begin
          case ({inc, dec})
            2'b10:   pend[c] <= pend[c] + PW'(1);
            2'b01:   pend[c] <= pend[c] - PW'(1);
            default: pend[c] <= pend[c];
          endcase
          bus.busy[c] <= (pend[c] != '0) | bus.core_busy[c];
        end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      cur          <= '0;
      gcnt         <= '0;
      bus.core_a0  <= 1'b0;
      bus.core_din <= '0;
    end else begin
      case (state)
        IDLE:
          if (pop) begin
            cur          <= head.chip;
            bus.core_a0  <= head.a0;
            bus.core_din <= head.d;
            gcnt         <= head.a0 ? GW'(GAP_DATA) : GW'(GAP_ADDR);
            state        <= ISSUE;
          end
        ISSUE:
          if (bus.cen) state <= GAP;
        GAP:
          if (gcnt == '0)   state <= IDLE;
          else if (bus.cen) gcnt  <= gcnt - GW'(1);
        default: state <= IDLE;
      endcase
    end

  // combinational from state so an async reset drops the strobe at once
  always_comb begin
    bus.core_wr = '0;
    if (state == ISSUE) bus.core_wr[cur] = 1'b1;
  end
endmodule
